memory_ctrl: RTL and testbench

//  Parametrised single-port SRAM controller with valid/ready request and rvalid/rready response channels.

---
 rtl/memory_pkg.sv | 18 +
 rtl/memory_array.sv | 69 ++++++
 rtl/memory_ctrl.sv | 146 ++++++++++++++
 tb/tb_memory_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and helpers for the SRAM controller slice.
package memory_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD_WAIT,
    RESP
  } state_t;

  localparam int unsigned MAX_RD_LATENCY = 4;

  // Even parity: the stored bit makes the total count of ones in lane+bit even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/memory_array.sv
// Byte-lane write-enabled storage with a registered read port.
// Optional per-lane parity columns when MEM_PARITY_EN is defined.
module memory_array
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned NB         = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [NB-1:0]         wstrb,
  output logic [WIDTH-1:0]      rdata,
  output logic                  perr
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Update only the lanes whose strobe is set.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wstrb[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Registered read; holds its value until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] rd_mismatch;

  // Parity bit for each lane is written together with its lane.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wstrb[k]) par[addr][k] <= byte_parity(wdata[8*k +: 8]);
      end
    end
  end

  // Per-lane comparison of stored parity against the stored data.
  always_comb begin
    rd_mismatch = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      rd_mismatch[k] = par[addr][k] ^ byte_parity(mem[addr][8*k +: 8]);
    end
  end

  // Parity error is registered alongside the read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    perr <= 1'b0;
    else if (re) perr <= |rd_mismatch;
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/memory_ctrl.sv
// Single-port SRAM controller: valid/ready requests, rvalid/rready responses,
// zero-fill init sweep, range check and configurable read latency.
// Define MEM_PARITY_EN to enable per-lane parity checking on reads.
module memory_ctrl
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned NB         = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_rd,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [NB-1:0]         wstrb,
  input  logic                  valid,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  err
);

  localparam int unsigned           LAT_W    = $clog2(MAX_RD_LATENCY);
  localparam logic [LAT_W-1:0]      LAT_LOAD = LAT_W'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep;
  logic [LAT_W-1:0]        lat_cnt;
  logic                    in_range;
  logic                    accept;
  logic                    arr_we;
  logic                    arr_re;
  logic [ADDR_WIDTH-1:0]   arr_addr;
  logic [WIDTH-1:0]        arr_wdata;
  logic [NB-1:0]           arr_wstrb;
  logic [WIDTH-1:0]        arr_rdata;
  logic                    arr_perr;

  // Range check and request acceptance.
  always_comb begin
    in_range = 32'(addr) < DEPTH;
    accept   = (state == IDLE) && valid && ready;
  end

  // Array port steering: the init sweep owns the port, otherwise accepted in-range requests.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = addr;
    arr_wdata = wdata;
    arr_wstrb = wstrb;
    if (state == INIT) begin
      arr_we    = 1'b1;
      arr_addr  = sweep;
      arr_wdata = '0;
      arr_wstrb = '1;
    end else if (accept && in_range) begin
      arr_we = wr_rd;
      arr_re = !wr_rd;
    end
  end

  memory_array #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NB         (NB)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .wstrb (arr_wstrb),
    .rdata (arr_rdata),
    .perr  (arr_perr)
  );

  // Controller FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= INIT;
      sweep   <= '0;
      lat_cnt <= '0;
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          sweep <= sweep + 1'b1;
          if (sweep == LAST) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            ready <= 1'b0;
            if (!in_range || wr_rd) begin
              state  <= RESP;
              rvalid <= 1'b1;
              err    <= !in_range;
              rdata  <= '0;
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= LAT_LOAD;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            state  <= RESP;
            rvalid <= 1'b1;
            rdata  <= arr_rdata;
            err    <= arr_perr;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rready) begin
            state  <= IDLE;
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
            ready  <= 1'b1;
          end
        end
        default: begin
          state <= INIT;
          sweep <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_ctrl.sv
// Scoreboard bench for memory_ctrl: DUT a (DEPTH 64, latency 1), DUT b (DEPTH 48, latency 3).
module tb_memory_ctrl;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst    [2];
  logic [5:0]  addr   [2];
  logic        wr_rd  [2];
  logic [15:0] wdata  [2];
  logic [1:0]  wstrb  [2];
  logic        valid  [2];
  logic        ready  [2];
  logic [15:0] rdata  [2];
  logic        rvalid [2];
  logic        rready [2];
  logic        err    [2];
  logic        prev_rv[2];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sbq0[$];
  exp_t sbq1[$];
  exp_t mon_e;
  bit   mon_have;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_ctrl #(.DEPTH(64), .WIDTH(16), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst[0]), .addr(addr[0]), .wr_rd(wr_rd[0]), .wdata(wdata[0]),
    .wstrb(wstrb[0]), .valid(valid[0]), .ready(ready[0]), .rdata(rdata[0]),
    .rvalid(rvalid[0]), .rready(rready[0]), .err(err[0])
  );

  memory_ctrl #(.DEPTH(48), .WIDTH(16), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst[1]), .addr(addr[1]), .wr_rd(wr_rd[1]), .wdata(wdata[1]),
    .wstrb(wstrb[1]), .valid(valid[1]), .ready(ready[1]), .rdata(rdata[1]),
    .rvalid(rvalid[1]), .rready(rready[1]), .err(err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Issue one request; the expected response (lat = edges after the accept edge) goes to the scoreboard.
  task automatic issue(input int d, input logic w, input logic [5:0] a, input logic [15:0] wd,
                       input logic [1:0] ws, input logic [15:0] er, input logic ee,
                       input int lat, input bit push);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!ready[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready[d]) begin
      timeout_fail($sformatf("accept_d%0d", d));
      return;
    end
    wr_rd[d] = w;
    addr[d]  = a;
    wdata[d] = wd;
    wstrb[d] = ws;
    valid[d] = 1'b1;
    e.rdata = er;
    e.err   = ee;
    e.lat   = lat;
    e.acc   = cyc;
    if (push) begin
      if (d == 0) sbq0.push_back(e);
      else        sbq1.push_back(e);
    end
    @(negedge clk);
    valid[d] = 1'b0;
  endtask

  task automatic wait_init(output int ka, output int kb);
    int k;
    ka = 0;
    kb = 0;
    k  = 0;
    while ((ka == 0 || kb == 0) && k < 200) begin
      @(negedge clk);
      k++;
      if (ready[0] && ka == 0) ka = k;
      if (ready[1] && kb == 0) kb = k;
    end
  endtask

  // Monitor: pop and compare on each rising rvalid.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rvalid[d] && !prev_rv[d]) begin
        mon_have = 1'b0;
        if (d == 0 && sbq0.size() > 0) begin
          mon_e = sbq0.pop_front();
          mon_have = 1'b1;
        end else if (d == 1 && sbq1.size() > 0) begin
          mon_e = sbq1.pop_front();
          mon_have = 1'b1;
        end
        if (!mon_have) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rvalid_d%0d: got rdata %h err %b, expected no response", d, rdata[d], err[d]);
        end else begin
          check($sformatf("rdata_d%0d", d), 32'(rdata[d]), 32'(mon_e.rdata));
          check($sformatf("err_d%0d", d), 32'(err[d]), 32'(mon_e.err));
          check($sformatf("latency_d%0d", d), 32'(cyc - mon_e.acc - 1), 32'(mon_e.lat));
        end
      end
      prev_rv[d] = rvalid[d];
    end
  end

  initial begin
    int ka, kb, k;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; valid[d] = 1'b0; wr_rd[d] = 1'b0; addr[d] = '0;
      wdata[d] = '0; wstrb[d] = '0; rready[d] = 1'b1; prev_rv[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready_d%0d", d), 32'(ready[d]), 32'd0);
      check($sformatf("rst_rvalid_d%0d", d), 32'(rvalid[d]), 32'd0);
      check($sformatf("rst_rdata_d%0d", d), 32'(rdata[d]), 32'd0);
      check($sformatf("rst_err_d%0d", d), 32'(err[d]), 32'd0);
    end
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    wait_init(ka, kb);
    check("init_cycles_a", 32'(ka), 32'd64);
    check("init_cycles_b", 32'(kb), 32'd48);

    // Freshly swept memory reads as zero.
    issue(0, 1'b0, 6'd5, 16'h0000, 2'b00, 16'h0000, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 6'd5, 16'h0000, 2'b00, 16'h0000, 1'b0, 3, 1'b1);

    // Byte-lane strobes on DUT a.
    issue(0, 1'b1, 6'd10, 16'hA5C3, 2'b11, 16'h0000, 1'b0, 0, 1'b1);
    issue(0, 1'b1, 6'd10, 16'h00FF, 2'b01, 16'h0000, 1'b0, 0, 1'b1);
    issue(0, 1'b0, 6'd10, 16'h0000, 2'b00, 16'hA5FF, 1'b0, 1, 1'b1);
    issue(0, 1'b1, 6'd10, 16'hFFFF, 2'b00, 16'h0000, 1'b0, 0, 1'b1);
    issue(0, 1'b0, 6'd10, 16'h0000, 2'b00, 16'hA5FF, 1'b0, 1, 1'b1);
    issue(0, 1'b1, 6'd10, 16'h3C00, 2'b10, 16'h0000, 1'b0, 0, 1'b1);
    issue(0, 1'b0, 6'd10, 16'h0000, 2'b00, 16'h3CFF, 1'b0, 1, 1'b1);
    issue(0, 1'b1, 6'd3,  16'h1234, 2'b11, 16'h0000, 1'b0, 0, 1'b1);
    issue(0, 1'b0, 6'd3,  16'h0000, 2'b00, 16'h1234, 1'b0, 1, 1'b1);

    // Range boundaries on DUT b (DEPTH 48).
    issue(1, 1'b1, 6'd47, 16'h1234, 2'b11, 16'h0000, 1'b0, 0, 1'b1);
    issue(1, 1'b0, 6'd47, 16'h0000, 2'b00, 16'h1234, 1'b0, 3, 1'b1);
    issue(1, 1'b0, 6'd50, 16'h0000, 2'b00, 16'h0000, 1'b1, 0, 1'b1);
    issue(1, 1'b1, 6'd48, 16'hFFFF, 2'b11, 16'h0000, 1'b1, 0, 1'b1);
    issue(1, 1'b0, 6'd63, 16'h0000, 2'b00, 16'h0000, 1'b1, 0, 1'b1);
    issue(1, 1'b0, 6'd47, 16'h0000, 2'b00, 16'h1234, 1'b0, 3, 1'b1);
    issue(1, 1'b0, 6'd0,  16'h0000, 2'b00, 16'h0000, 1'b0, 3, 1'b1);

    // Response held under rready=0 back-pressure.
    rready[0] = 1'b0;
    issue(0, 1'b0, 6'd10, 16'h0000, 2'b00, 16'h3CFF, 1'b0, 1, 1'b1);
    k = 0;
    while (!rvalid[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!rvalid[0]) timeout_fail("hold_rvalid_wait");
    repeat (5) begin
      @(negedge clk);
      check("hold_rvalid", 32'(rvalid[0]), 32'd1);
      check("hold_rdata", 32'(rdata[0]), 32'h3CFF);
      check("hold_err", 32'(err[0]), 32'd0);
      check("hold_ready", 32'(ready[0]), 32'd0);
    end
    rready[0] = 1'b1;
    @(negedge clk);
    check("ready_after_handshake", 32'(ready[0]), 32'd1);
    check("rvalid_after_handshake", 32'(rvalid[0]), 32'd0);

    // Reset during RD_WAIT on DUT b: no response, sweep reruns and clears memory.
    issue(1, 1'b0, 6'd47, 16'h0000, 2'b00, 16'h0000, 1'b0, 3, 1'b0);
    rst[1] = 1'b0;
    #1;
    check("midrst_ready", 32'(ready[1]), 32'd0);
    check("midrst_rvalid", 32'(rvalid[1]), 32'd0);
    check("midrst_rdata", 32'(rdata[1]), 32'd0);
    check("midrst_err", 32'(err[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst[1] = 1'b1;
    k = 0;
    while (!ready[1] && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reinit_cycles_b", 32'(k), 32'd48);
    issue(1, 1'b0, 6'd47, 16'h0000, 2'b00, 16'h0000, 1'b0, 3, 1'b1);

    k = 0;
    while ((sbq0.size() > 0 || sbq1.size() > 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sbq0.size() > 0 || sbq1.size() > 0) timeout_fail("scoreboard_drain");
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
